// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin arbitration over valid/ready request ports, an issue stage (S1)
// that drives the ALU inputs, and a response stage (S2) that captures the ALU
// result and returns it to the owning requester over valid/ready.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req{0,1}_valid/ready          request handshake
//   req{0,1}_srca/srcb/op         request operands and ALU operation code
//   resp{0,1}_valid/ready         response handshake
//   resp{0,1}_result              result; holds last value when not valid
//   alu_srca/alu_srcb/alu_op      to the ALU (always the S1 registers)
//   alu_result                    from the ALU, combinational of alu_*
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     resp0_valid,
  input  logic                     resp0_ready,
  output logic [DATA_WIDTH-1:0]    resp0_result,
  output logic                     resp1_valid,
  input  logic                     resp1_ready,
  output logic [DATA_WIDTH-1:0]    resp1_result,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  // Issue stage
  logic                     s1_v;
  logic                     s1_owner;
  logic [DATA_WIDTH-1:0]    s1_a;
  logic [DATA_WIDTH-1:0]    s1_b;
  logic [OPCODE_LENGTH-1:0] s1_op;

  // Response stage
  logic                     s2_v;
  logic                     s2_owner;
  logic [DATA_WIDTH-1:0]    s2_res;

  // Per-port copies of the last delivered result, shown while not valid
  logic [DATA_WIDTH-1:0]    hold0;
  logic [DATA_WIDTH-1:0]    hold1;

  logic                     last_grant;

  logic consume;
  logic s2_free;
  logic s1_free;
  logic move;
  logic grant_v;
  logic grant;
  logic accept;

  // Flow control, arbitration and request handshakes
  always_comb begin
    consume    = 1'b0;
    s2_free    = 1'b0;
    s1_free    = 1'b0;
    move       = 1'b0;
    grant_v    = 1'b0;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;

    consume = s2_v && (s2_owner ? resp1_ready : resp0_ready);
    s2_free = !s2_v || consume;
    s1_free = !s1_v || s2_free;
    move    = s1_v && s2_free;

    grant_v = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      grant = !last_grant;
    end else begin
      grant = req1_valid;
    end

    req0_ready = s1_free && grant_v && !grant && req0_valid && !reset;
    req1_ready = s1_free && grant_v &&  grant && req1_valid && !reset;
    accept     = req0_ready || req1_ready;
  end

  // Pipeline state; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v       <= 1'b0;
      s1_owner   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s2_v       <= 1'b0;
      s2_owner   <= 1'b0;
      s2_res     <= '0;
      hold0      <= '0;
      hold1      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        s1_v       <= 1'b1;
        s1_owner   <= req1_ready;
        s1_a       <= req1_ready ? req1_srca : req0_srca;
        s1_b       <= req1_ready ? req1_srcb : req0_srcb;
        s1_op      <= req1_ready ? req1_op   : req0_op;
        last_grant <= req1_ready;
      end else if (move) begin
        s1_v <= 1'b0;
      end

      if (move) begin
        s2_v     <= 1'b1;
        s2_owner <= s1_owner;
        s2_res   <= alu_result;
      end else if (consume) begin
        s2_v <= 1'b0;
      end

      if (s2_v && !s2_owner) hold0 <= s2_res;
      if (s2_v &&  s2_owner) hold1 <= s2_res;
    end
  end

  assign alu_srca = s1_a;
  assign alu_srcb = s1_b;
  assign alu_op   = s1_op;

  assign resp0_valid  = s2_v && !s2_owner;
  assign resp1_valid  = s2_v &&  s2_owner;
  assign resp0_result = resp0_valid ? s2_res : hold0;
  assign resp1_result = resp1_valid ? s2_res : hold1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU and a
// per-requester scoreboard (expected results queued at accept, checked when
// the response handshake completes).
module tb_alu_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned OL = 4;

  localparam logic [OL-1:0] OP_AND = 4'b0000;
  localparam logic [OL-1:0] OP_OR  = 4'b0001;
  localparam logic [OL-1:0] OP_ADD = 4'b0010;
  localparam logic [OL-1:0] OP_XOR = 4'b0011;
  localparam logic [OL-1:0] OP_SLL = 4'b0100;
  localparam logic [OL-1:0] OP_SUB = 4'b0110;
  localparam logic [OL-1:0] OP_BAD = 4'b1111;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [OL-1:0] req0_op, req1_op;
  logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [DW-1:0] resp0_result, resp1_result;
  logic [DW-1:0] alu_srca, alu_srcb, alu_result;
  logic [OL-1:0] alu_op;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  logic acc0, acc1;

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .alu_result(alu_result)
  );

  function automatic logic [DW-1:0] ref_alu(input logic [OL-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the external combinational ALU
  always_comb alu_result = ref_alu(alu_op, alu_srca, alu_srcb);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes just before the edge, then advance past it
  task automatic cycle();
    logic [DW-1:0] e;
    #1;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (acc0) exp0.push_back(ref_alu(req0_op, req0_srca, req0_srcb));
    if (acc1) exp1.push_back(ref_alu(req1_op, req1_srca, req1_srcb));
    if (resp0_valid && resp0_ready) begin
      if (exp0.size() == 0) check("sb0_unexpected", resp0_result, 'x);
      else begin e = exp0.pop_front(); check("sb0_result", resp0_result, e); end
    end
    if (resp1_valid && resp1_ready) begin
      if (exp1.size() == 0) check("sb1_unexpected", resp1_result, 'x);
      else begin e = exp1.pop_front(); check("sb1_result", resp1_result, e); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [OL-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_srca = a; req0_srcb = b;
    end else begin
      req1_valid = v; req1_op = op; req1_srca = a; req1_srcb = b;
    end
  endtask

  // One reset cycle; requests keep whatever valid they had to prove ready stays low
  task automatic do_reset();
    reset = 1'b1;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'(0));
    check("rst_req1_ready", 32'(req1_ready), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp0.delete();
    exp1.delete();
    check("rst_resp0_valid", 32'(resp0_valid), 32'(0));
    check("rst_resp1_valid", 32'(resp1_valid), 32'(0));
    check("rst_alu_op", 32'(alu_op), 32'(0));
    check("rst_alu_srca", alu_srca, 32'(0));
    check("rst_alu_srcb", alu_srcb, 32'(0));
    check("rst_resp0_result", resp0_result, 32'(0));
    check("rst_resp1_result", resp1_result, 32'(0));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!req0_valid && !req1_valid && exp0.size() == 0 && exp1.size() == 0) break;
      cycle();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    check({tag, "_q0_empty"}, 32'(exp0.size()), 32'(0));
    check({tag, "_q1_empty"}, 32'(exp1.size()), 32'(0));
  endtask

  initial begin
    reset = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd9, 32'd9);
    set_req(1, 1'b0, OP_AND, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Single ADD on port 0: ready same cycle, response after the second edge
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    check("t1_req0_ready", 32'(req0_ready), 32'(1));
    cycle();
    req0_valid = 1'b0;
    check("t1_resp0_valid_early", 32'(resp0_valid), 32'(0));
    cycle();
    check("t1_resp0_valid", 32'(resp0_valid), 32'(1));
    check("t1_resp1_valid", 32'(resp1_valid), 32'(0));
    check("t1_result", resp0_result, 32'd12);
    drain("t1");

    // Contention every cycle: grants alternate starting with port 0
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, OP_XOR, 32'hF0, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
      check("t2_req1_ready", 32'(req1_ready), 32'(i % 2 == 1));
      cycle();
      if (i >= 1) begin
        check("t2_resp0_valid", 32'(resp0_valid), 32'((i - 1) % 2 == 0));
        check("t2_resp1_valid", 32'(resp1_valid), 32'((i - 1) % 2 == 1));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain("t2");

    // Back-to-back shifts on port 1
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, OP_SLL, 32'd1, DW'(k));
      #1;
      check("t3_req1_ready", 32'(req1_ready), 32'(1));
      cycle();
      if (k >= 1) begin
        check("t3_resp1_valid", 32'(resp1_valid), 32'(1));
        check("t3_resp1_result", resp1_result, 32'(1) << (k - 1));
      end
    end
    req1_valid = 1'b0;
    drain("t3");

    // Undefined opcode returns whatever the ALU gives (0)
    set_req(1, 1'b1, OP_BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cycle();
    req1_valid = 1'b0;
    cycle();
    check("t6_resp1_valid", 32'(resp1_valid), 32'(1));
    check("t6_resp1_result", resp1_result, 32'd0);
    drain("t6");

    // Backpressure on port 0 stalls both requesters
    resp0_ready = 1'b0;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    cycle();
    set_req(0, 1'b1, OP_ADD, 32'd2, 32'd2);
    set_req(1, 1'b1, OP_ADD, 32'd3, 32'd3);
    cycle();
    check("t4_req1_taken", 32'(acc1), 32'(1));
    set_req(1, 1'b1, OP_ADD, 32'd4, 32'd4);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_req0_ready", 32'(req0_ready), 32'(0));
      check("t4_req1_ready", 32'(req1_ready), 32'(0));
      check("t4_resp0_valid", 32'(resp0_valid), 32'(1));
      check("t4_resp0_result", resp0_result, 32'd2);
      cycle();
    end
    resp0_ready = 1'b1;
    drain("t4");

    // Reset with both stages occupied
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    set_req(1, 1'b1, OP_OR, 32'd3, 32'd4);
    cycle();
    cycle();
    check("t5_inflight", 32'(resp0_valid || resp1_valid), 32'(1));
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd20, 32'd22);
    set_req(1, 1'b1, OP_ADD, 32'd30, 32'd32);
    #1;
    check("t5_first_grant0", 32'(req0_ready), 32'(1));
    check("t5_first_grant1", 32'(req1_ready), 32'(0));
    drain("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
